layer_1_result_reader: RTL
==========================

# layer_1_result_reader

Reader at the consuming end of the layer-1 result interface. Captures all twenty 32-bit leaky-ReLU outputs in the cycle that layer 1 raises its completion strobe. It then drains them one word per handshake over a valid/ready stream to the next layer or a host port. It also flags results that arrive while a drain is still in progress.

## Interface
- DATA_SIZE, 32, width of each captured result (2*OUTPUT_BUT_SIZE of layer 1)
- NUM_RESULTS, 20, number of result words; ports are fixed at 20 and this value must be 20
- INDEX_SIZE, 5, width of the index outputs
- clk  input  1  single clock; all state changes on rising edge
- reset  input  1  asynchronous, active-low reset
- load  input  1  capture strobe, driven by layer 1 done_complete
- layer_1_input_1 .. layer_1_input_20  input  DATA_SIZE each  results to capture (signed two's complement)
- out_data  output  DATA_SIZE  current result word
- out_index  output  INDEX_SIZE  index of out_data, 0..19 (0 = layer_1_input_1)
- out_valid  output  1  out_data/out_index/out_last are valid
- out_ready  input  1  downstream accepts the word
- out_last  output  1  high with index 19
- busy  output  1  high while in STREAM
- done  output  1  one-cycle pulse after the final word is accepted
- overrun  output  1  sticky: a load arrived while busy
- argmax_index  output  INDEX_SIZE  index of the largest result (see Configuration)
- argmax_value  output  DATA_SIZE  value of the largest result (see Configuration)

## Operation
- States: IDLE, STREAM.
- IDLE, load=1: register all 20 inputs into buf[0..19], set idx=0, go to STREAM. With load=0, stay in IDLE.
- STREAM outputs:
  - out_valid=1, out_data=buf[idx], out_index=idx, out_last=(idx==19).
  - Outputs come straight from registers; no combinational path from out_ready to any output.
- Handshake = out_valid & out_ready.
  - On a handshake with idx<19: idx increments.
  - On a handshake with idx==19: go to IDLE, set done=1 for the next cycle, idx=0.
  - Without a handshake, all outputs hold.
- load in STREAM, including the final-handshake cycle: ignored (buffer unchanged) and overrun is set to 1. overrun clears only on reset.
- In IDLE: out_valid=0, out_last=0, out_data=0, out_index=0.
- Reset values: out_valid=0, out_last=0, out_data=0, out_index=0, busy=0, done=0, overrun=0, argmax_index=0, argmax_value=0. Buffer contents are don't-care; state=IDLE, idx=0.
- Reset asserted mid-stream: the drain is aborted immediately (asynchronously), with no done pulse. After release, the block is in IDLE awaiting a new load.

## Timing
- Capture edge T (load sampled high in IDLE): out_valid, busy and word 0 are visible from T+1.
- With out_ready held high: words 0..19 are accepted on edges T+1..T+20, and done is high during cycle T+21.
- Throughput is one word per cycle. out_ready may toggle arbitrarily; each word is accepted exactly once, in order.
- busy falls in the same cycle done rises. A load sampled in that cycle is captured normally.

## Configuration
- LAYER_1_READER_ARGMAX_EN defined:
  - A running signed maximum is tracked during STREAM.
  - On word 0's handshake, the running max is loaded unconditionally. On later handshakes it is replaced only if the word is strictly greater; ties keep the lower index.
  - argmax_index/argmax_value are updated to the final max in the same edge that raises done, and hold until the next done.
- LAYER_1_READER_ARGMAX_EN undefined: no compare logic is built, and argmax_index and argmax_value are constant 0.

## Test plan
- Capture of inputs i=1..20 with value 32'h100*i, out_ready=1: out_index 0..19 on consecutive cycles, out_data 32'h100..32'h1400, out_last only at index 19, done pulses exactly at T+21, overrun=0.
- Backpressure with out_ready alternating 1,0,1,0 and a 3-cycle stall at index 7: no word is lost or duplicated, out_data stable while stalled, done at the cycle after the 20th handshake.
- load re-pulsed at index 5, and separately in the final-handshake cycle: stream completes with the original data, overrun=1 stays high until reset. A load in the cycle done is high is captured and a new stream starts the next cycle.
- Reset (reset=0) asserted asynchronously at index 10: out_valid/busy drop without waiting for a clock edge, no done. A new load after release streams the fresh data from index 0.
- ARGMAX_EN with values {-5, 32'h7FFF_FFFF at i=4, 32'h7FFF_FFFF at i=12, others 0}: argmax_index=3, argmax_value=32'h7FFF_FFFF. With all inputs 32'hFFFF_FFF0: argmax_index=0, value 32'hFFFF_FFF0. Without the macro, both are 0 throughout.

Source files
------------

// File: rtl/layer_1_result_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : layer_1_result_reader_if
// Description : Valid/ready result stream carrying one layer-1 result word
//               per handshake, plus its index and a last-word marker.
//               master : the reader (drives data/index/valid/last)
//               slave  : the consumer (drives out_ready)
// Ports       : out_data  [DATA_SIZE]   current result word
//               out_index [INDEX_SIZE]  index of out_data (0..19)
//               out_valid               data/index/last are valid
//               out_ready               consumer accepts the word
//               out_last                high with the final index
// Revision    : 1.0  initial release
// ============================================================================
interface layer_1_result_reader_if #(
  parameter int DATA_SIZE  = 32,
  parameter int INDEX_SIZE = 5
);
  logic [DATA_SIZE-1:0]  out_data;
  logic [INDEX_SIZE-1:0] out_index;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;

  modport master (
    output out_data,
    output out_index,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_index,
    input  out_valid,
    input  out_last,
    output out_ready
  );
endinterface
`default_nettype wire

// File: rtl/layer_1_result_reader.sv
`default_nettype none
// ============================================================================
// Module      : layer_1_result_reader
// Description : Captures all twenty layer-1 leaky-ReLU results on the load
//               strobe and drains them one word per handshake over a
//               valid/ready stream. Flags loads that arrive mid-drain.
// Ports       : clk                  rising-edge clock
//               reset                asynchronous active-low reset
//               load                 capture strobe (layer 1 done_complete)
//               layer_1_input_1..20  results to capture (signed)
//               out_if (master)      out_data/out_index/out_valid/
//                                    out_ready/out_last stream
//               busy                 high while streaming
//               done                 one-cycle pulse after the final word
//               overrun              sticky: load seen while busy
//               argmax_index/value   largest result of the last drain
// Options     : LAYER_1_READER_ARGMAX_EN  build the running signed maximum;
//               when undefined argmax_index/argmax_value are constant 0.
// Revision    : 1.0  initial release
// ============================================================================
module layer_1_result_reader #(
  parameter int DATA_SIZE   = 32,
  parameter int NUM_RESULTS = 20,  // ports are fixed at 20; must stay 20
  parameter int INDEX_SIZE  = 5
) (
  input  wire logic                  clk,
  input  wire logic                  reset,
  input  wire logic                  load,
  input  wire logic [DATA_SIZE-1:0]  layer_1_input_1,
  input  wire logic [DATA_SIZE-1:0]  layer_1_input_2,
  input  wire logic [DATA_SIZE-1:0]  layer_1_input_3,
  input  wire logic [DATA_SIZE-1:0]  layer_1_input_4,
  input  wire logic [DATA_SIZE-1:0]  layer_1_input_5,
  input  wire logic [DATA_SIZE-1:0]  layer_1_input_6,
  input  wire logic [DATA_SIZE-1:0]  layer_1_input_7,
  input  wire logic [DATA_SIZE-1:0]  layer_1_input_8,
  input  wire logic [DATA_SIZE-1:0]  layer_1_input_9,
  input  wire logic [DATA_SIZE-1:0]  layer_1_input_10,
  input  wire logic [DATA_SIZE-1:0]  layer_1_input_11,
  input  wire logic [DATA_SIZE-1:0]  layer_1_input_12,
  input  wire logic [DATA_SIZE-1:0]  layer_1_input_13,
  input  wire logic [DATA_SIZE-1:0]  layer_1_input_14,
  input  wire logic [DATA_SIZE-1:0]  layer_1_input_15,
  input  wire logic [DATA_SIZE-1:0]  layer_1_input_16,
  input  wire logic [DATA_SIZE-1:0]  layer_1_input_17,
  input  wire logic [DATA_SIZE-1:0]  layer_1_input_18,
  input  wire logic [DATA_SIZE-1:0]  layer_1_input_19,
  input  wire logic [DATA_SIZE-1:0]  layer_1_input_20,
  layer_1_result_reader_if.master    out_if,
  output logic                       busy,
  output logic                       done,
  output logic                       overrun,
  output logic [INDEX_SIZE-1:0]      argmax_index,
  output logic [DATA_SIZE-1:0]       argmax_value
);

  localparam logic [INDEX_SIZE-1:0] c_LAST_IDX = INDEX_SIZE'(NUM_RESULTS - 1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  state_t                r_state;
  logic [DATA_SIZE-1:0]  r_buf [0:NUM_RESULTS-1];
  logic [DATA_SIZE-1:0]  r_out_data;
  // The registered out_index doubles as the drain pointer (idx).
  logic [INDEX_SIZE-1:0] r_out_index;
  logic                  r_out_valid;
  logic                  r_out_last;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_overrun;

  logic [DATA_SIZE-1:0]  w_in [0:NUM_RESULTS-1];
  logic                  w_capture;
  logic                  w_handshake;
  logic [INDEX_SIZE-1:0] w_next_index;

  assign w_in[0]  = layer_1_input_1;
  assign w_in[1]  = layer_1_input_2;
  assign w_in[2]  = layer_1_input_3;
  assign w_in[3]  = layer_1_input_4;
  assign w_in[4]  = layer_1_input_5;
  assign w_in[5]  = layer_1_input_6;
  assign w_in[6]  = layer_1_input_7;
  assign w_in[7]  = layer_1_input_8;
  assign w_in[8]  = layer_1_input_9;
  assign w_in[9]  = layer_1_input_10;
  assign w_in[10] = layer_1_input_11;
  assign w_in[11] = layer_1_input_12;
  assign w_in[12] = layer_1_input_13;
  assign w_in[13] = layer_1_input_14;
  assign w_in[14] = layer_1_input_15;
  assign w_in[15] = layer_1_input_16;
  assign w_in[16] = layer_1_input_17;
  assign w_in[17] = layer_1_input_18;
  assign w_in[18] = layer_1_input_19;
  assign w_in[19] = layer_1_input_20;

  // Loads are only honoured in IDLE; a load while streaming leaves the
  // buffer untouched so the drain in progress completes with its own data.
  assign w_capture    = (r_state == ST_IDLE) && load;
  assign w_handshake  = (r_state == ST_STREAM) && out_if.out_ready;
  assign w_next_index = r_out_index + INDEX_SIZE'(1);

  // Result buffer has no reset: its contents only matter after a capture.
  always_ff @(posedge clk) begin
    if (w_capture) begin
      for (int i = 0; i < NUM_RESULTS; i++) begin
        r_buf[i] <= w_in[i];
      end
    end
  end

  // Control FSM; every stream output is a register so out_ready never
  // reaches an output combinationally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_out_data  <= '0;
      r_out_index <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (load) begin
            r_state     <= ST_STREAM;
            r_out_data  <= w_in[0];
            r_out_index <= '0;
            r_out_valid <= 1'b1;
            r_out_last  <= (c_LAST_IDX == '0);
            r_busy      <= 1'b1;
          end
        end
        ST_STREAM: begin
          if (load) begin
            r_overrun <= 1'b1;
          end
          if (w_handshake) begin
            if (r_out_index == c_LAST_IDX) begin
              r_state     <= ST_IDLE;
              r_out_data  <= '0;
              r_out_index <= '0;
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
            end else begin
              r_out_data  <= r_buf[w_next_index];
              r_out_index <= w_next_index;
              r_out_last  <= (w_next_index == c_LAST_IDX);
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign out_if.out_data  = r_out_data;
  assign out_if.out_index = r_out_index;
  assign out_if.out_valid = r_out_valid;
  assign out_if.out_last  = r_out_last;
  assign busy             = r_busy;
  assign done             = r_done;
  assign overrun          = r_overrun;

`ifdef LAYER_1_READER_ARGMAX_EN
  logic [DATA_SIZE-1:0]  r_max_val;
  logic [INDEX_SIZE-1:0] r_max_idx;
  logic [DATA_SIZE-1:0]  r_argmax_value;
  logic [INDEX_SIZE-1:0] r_argmax_index;
  logic                  w_take;
  logic [DATA_SIZE-1:0]  w_next_max_val;
  logic [INDEX_SIZE-1:0] w_next_max_idx;

  // Word 0 seeds the running max; later words must be strictly greater,
  // so on ties the lower index wins.
  always_comb begin
    w_take         = (r_out_index == '0) ||
                     ($signed(r_out_data) > $signed(r_max_val));
    w_next_max_val = w_take ? r_out_data  : r_max_val;
    w_next_max_idx = w_take ? r_out_index : r_max_idx;
  end

  // Published result moves on the same edge that raises done and then
  // holds until the next completed drain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_max_val      <= '0;
      r_max_idx      <= '0;
      r_argmax_value <= '0;
      r_argmax_index <= '0;
    end else if (w_handshake) begin
      r_max_val <= w_next_max_val;
      r_max_idx <= w_next_max_idx;
      if (r_out_index == c_LAST_IDX) begin
        r_argmax_value <= w_next_max_val;
        r_argmax_index <= w_next_max_idx;
      end
    end
  end

  assign argmax_index = r_argmax_index;
  assign argmax_value = r_argmax_value;
`else
  assign argmax_index = '0;
  assign argmax_value = '0;
`endif

endmodule
`default_nettype wire
